coord_bcd_converter: RTL
========================

// Module: coord_bcd_converter
//
// PURPOSE
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns
// a mouse coordinate into four decimal digits for the seven-segment display stage.
// Sits between the mouse position registers and the display wrapper. Its NUM0..NUM3
// outputs drive the wrapper's digit inputs directly.
// Outputs hold the last completed result, so the display never shows partial values.
//
// PARAMETERS
// BIN_WIDTH  14  width of BIN_IN. Legal range 4..20; 14 covers 0..9999.
//
// PORTS
// CLK       in   1          system clock, 100 MHz
// RESETN    in   1          asynchronous active-low reset
// START     in   1          conversion request, sampled only in IDLE
// BIN_IN    in   BIN_WIDTH  unsigned value to convert, captured when START is accepted
// BUSY      out  1          high while a conversion is in progress (state != IDLE)
// DONE      out  1          one-cycle pulse; NUM0..NUM3 and OVERFLOW valid from this cycle
// OVERFLOW  out  1          last captured value exceeded 9999 (result saturated)
// NUM0      out  4          BCD units digit
// NUM1      out  4          BCD tens digit
// NUM2      out  4          BCD hundreds digit
// NUM3      out  4          BCD thousands digit
//
// BEHAVIOUR
// - Reset (RESETN=0, asynchronous):
//   - state=IDLE; BUSY=0, DONE=0, OVERFLOW=0, NUM0..NUM3=0
//   - internal shift register and bit counter cleared
// - FSM states: IDLE -> SHIFT -> FINISH -> IDLE.
// - IDLE, START=1 at edge k (accept):
//   - capture sat = (BIN_IN > 9999) ? 9999 : BIN_IN
//   - compare at max(BIN_WIDTH,14) bits; widths below 14 can never saturate
//   - latch ovf_pend = (BIN_IN > 9999)
//   - clear 16-bit BCD scratch; bit counter = 0; go to SHIFT
// - SHIFT, one step per edge:
//   - for each scratch nibble >= 5, add 3
//   - then shift {scratch, sat} left by 1
//   - increment counter
//   - after BIN_WIDTH steps (edges k+1..k+BIN_WIDTH), go to FINISH
// - FINISH entry (edge k+BIN_WIDTH):
//   - on the next edge k+BIN_WIDTH+1: NUM3..NUM0 <= scratch[15:0], OVERFLOW <= ovf_pend
//   - DONE=1 for that one cycle; state -> IDLE
// - Latency:
//   - DONE is high in the cycle after edge k+BIN_WIDTH+1
//   - START accepted to result valid = BIN_WIDTH+1 clocks (15 for default)
// - BUSY:
//   - 1 from edge k through edge k+BIN_WIDTH+1
//   - low again in the DONE cycle, so back-to-back STARTs are possible
// - START while BUSY=1 is ignored: no queueing, no effect on the current conversion.
//   START held high continuously re-triggers a new conversion every BIN_WIDTH+2 cycles.
// - START in the DONE cycle (state=IDLE) is accepted normally.
// - BIN_IN changes after capture have no effect on the current conversion.
// - NUM0..NUM3 and OVERFLOW change only on the DONE edge; otherwise they hold.
// - Reset mid-conversion aborts the conversion: outputs go to zero, no DONE pulse.
// - All outputs are registered; no combinational path from inputs to outputs.
//
// TESTING
// 1. Reset, then START with BIN_IN=0
//    -> DONE after 15 clk; NUM3..0=0,0,0,0; OVERFLOW=0
// 2. BIN_IN=1234, START
//    -> BUSY high for 15 clk; DONE 1 cycle; NUM3..0=1,2,3,4
// 3. BIN_IN=9999, then BIN_IN=12000
//    -> first: 9,9,9,9 with OVERFLOW=0
//    -> second: 9,9,9,9 with OVERFLOW=1
// 4. Start 1234, pulse START with BIN_IN=5678 at cycle 5, change BIN_IN mid-run
//    -> single DONE; result 1,2,3,4
// 5. START held high with BIN_IN=42
//    -> DONE every 16 clk; NUM=0,0,4,2; outputs stable between pulses
// 6. Convert 777, then start 8888 and assert RESETN=0 at cycle 7
//    -> NUM=0 and BUSY=0 immediately; no DONE
//    -> after release, START with 31 -> 0,0,3,1

Source files
------------

// File: rtl/coord_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the mouse coordinate display.
// One input bit is consumed per clock; outputs hold the last completed result.
module coord_bcd_converter #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic [BIN_WIDTH-1:0] BIN_IN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERFLOW,
  output logic [3:0]           NUM0,
  output logic [3:0]           NUM1,
  output logic [3:0]           NUM2,
  output logic [3:0]           NUM3
);

  // Saturation compare is done at least 14 bits wide so narrow inputs never saturate.
  localparam int CMP_W = (BIN_WIDTH > 14) ? BIN_WIDTH : 14;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [15:0]          bcd_sr;
  logic [15:0]          bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ovf_pend;
  logic                 accept;
  logic                 last_step;
  logic                 in_range;
  logic [BIN_WIDTH-1:0] sat_val;

  assign accept    = (state == IDLE) && START;
  assign last_step = (bit_cnt == CNT_W'(BIN_WIDTH - 1));
  assign in_range  = (CMP_W'(BIN_IN) <= CMP_W'(9999));
  assign sat_val   = in_range ? BIN_IN : BIN_WIDTH'(9999);
  assign BUSY      = (state != IDLE);

  // Add-3 correction on every nibble that would exceed 9 after the doubling shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      DONE     <= 1'b0;
      OVERFLOW <= 1'b0;
      NUM0     <= '0;
      NUM1     <= '0;
      NUM2     <= '0;
      NUM3     <= '0;
    end else begin
      DONE <= (state == FINISH);
      if (accept) begin
        bin_sr   <= sat_val;
        bcd_sr   <= '0;
        bit_cnt  <= '0;
        ovf_pend <= !in_range;
      end else if (state == SHIFT) begin
        bcd_sr  <= {bcd_adj[14:0], bin_sr[BIN_WIDTH-1]};
        bin_sr  <= bin_sr << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (state == FINISH) begin
        {NUM3, NUM2, NUM1, NUM0} <= bcd_sr;
        OVERFLOW                 <= ovf_pend;
      end
    end
  end

endmodule
